// File: rtl/ws2812_chain.sv
// WS2812/SK6812 chain driver: per-LED colour registers serialised onto one NRZ data line.
// Optional global brightness scaling at word load is enabled by defining WS2812_CHAIN_BRIGHTNESS_EN.
module ws2812_chain #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int T0H_CYC      = 4,
  parameter int T1H_CYC      = 8,
  parameter int TBIT_CYC     = 15,
  parameter int TRESET_CYC   = 720,
  parameter int AUTO_REFRESH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [NUM_LEDS-1:0]     led_mask,
  input  logic [BITS_PER_LED-1:0] colour,
  input  logic [7:0]              brightness,
  input  logic                    refresh,
  output logic                    data,
  output logic                    busy,
  output logic                    frame_done,
  output logic [2:0]              state_dbg
);

  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int TW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
  localparam int RW = (TRESET_CYC > 1) ? $clog2(TRESET_CYC) : 1;

  localparam logic [LW-1:0] LED_LAST  = LW'(NUM_LEDS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_LED - 1);
  localparam logic [TW-1:0] TBIT_LAST = TW'(TBIT_CYC - 1);
  localparam logic [TW-1:0] T1H_LAST  = TW'(T1H_CYC - 1);
  localparam logic [TW-1:0] T0H_LAST  = TW'(T0H_CYC - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(TRESET_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_BIT_HIGH = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_LATCH    = 3'd4
  } state_t;

  // Free-running mode starts in LATCH so the first frame follows a full low gap.
  localparam state_t RESET_STATE = (AUTO_REFRESH != 0) ? S_LATCH : S_IDLE;

  state_t                  state;
  logic [BITS_PER_LED-1:0] led_reg [NUM_LEDS];
  logic [BITS_PER_LED-1:0] shift;
  logic [BITS_PER_LED-1:0] load_word;
  logic [LW-1:0]           led_cnt;
  logic [LW-1:0]           next_led;
  logic [LW-1:0]           fetch_idx;
  logic [BW-1:0]           bit_cnt;
  logic [TW-1:0]           t_cnt;
  logic [RW-1:0]           lat_cnt;
  logic                    pending;
  logic                    refresh_req;

  assign state_dbg   = state;
  assign next_led    = led_cnt + 1'b1;
  assign refresh_req = (AUTO_REFRESH == 0) && refresh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEDS; i++) led_reg[i] <= '0;
    end else if (write) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (led_mask[i]) led_reg[i] <= colour;
      end
    end
  end

`ifdef WS2812_CHAIN_BRIGHTNESS_EN
  function automatic logic [BITS_PER_LED-1:0] scale_word(input logic [BITS_PER_LED-1:0] w,
                                                        input logic [7:0] b);
    logic [15:0] prod;
    scale_word = w;
    for (int f = 0; f < BITS_PER_LED / 8; f++) begin
      prod = {8'd0, w[f*8 +: 8]} * ({8'd0, b} + 16'd1);
      scale_word[f*8 +: 8] = prod[15:8];
    end
  endfunction
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // LOAD fetches the first LED; the last bit of every other LED fetches the following one.
  always_comb begin
    fetch_idx = (state == S_LOAD) ? led_cnt : next_led;
`ifdef WS2812_CHAIN_BRIGHTNESS_EN
    load_word = scale_word(led_reg[fetch_idx], brightness);
`else
    load_word = led_reg[fetch_idx];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      data       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      led_cnt    <= '0;
      bit_cnt    <= '0;
      t_cnt      <= '0;
      lat_cnt    <= '0;
      pending    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (refresh_req && (state != S_IDLE)) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          data <= 1'b0;
          busy <= 1'b0;
          if ((AUTO_REFRESH != 0) || pending || refresh_req) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        S_LOAD: begin
          shift   <= load_word;
          bit_cnt <= '0;
          t_cnt   <= '0;
          data    <= 1'b1;
          state   <= S_BIT_HIGH;
        end
        S_BIT_HIGH: begin
          t_cnt <= t_cnt + 1'b1;
          if (t_cnt == (shift[BITS_PER_LED-1] ? T1H_LAST : T0H_LAST)) begin
            data  <= 1'b0;
            state <= S_BIT_LOW;
          end
        end
        S_BIT_LOW: begin
          if (t_cnt == TBIT_LAST) begin
            t_cnt <= '0;
            if (bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {shift[BITS_PER_LED-2:0], 1'b0};
              data    <= 1'b1;
              state   <= S_BIT_HIGH;
            end else if (led_cnt != LED_LAST) begin
              led_cnt <= next_led;
              bit_cnt <= '0;
              shift   <= load_word;
              data    <= 1'b1;
              state   <= S_BIT_HIGH;
            end else begin
              led_cnt <= '0;
              bit_cnt <= '0;
              lat_cnt <= '0;
              data    <= 1'b0;
              state   <= S_LATCH;
            end
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          data <= 1'b0;
          if (lat_cnt == RST_LAST) begin
            lat_cnt    <= '0;
            frame_done <= 1'b1;
            if ((AUTO_REFRESH != 0) || pending || refresh_req) begin
              state   <= S_LOAD;
              busy    <= 1'b1;
              pending <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          data    <= 1'b0;
          busy    <= 1'b0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain: on-demand 4-LED chain decoded against a scoreboard,
// a free-running chain for frame timing, and a 32-bit chain for RGBW words.
module tb_ws2812_chain;
  localparam int NL        = 4;
  localparam int BPL       = 24;
  localparam int T0H       = 4;
  localparam int T1H       = 8;
  localparam int TBIT      = 15;
  localparam int TRST      = 720;
  localparam int FRAME_CYC = NL * BPL * TBIT + TRST + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [7:0] brightness;

  // on-demand chain
  logic          write_a, refresh_a;
  logic [NL-1:0] mask_a;
  logic [BPL-1:0] colour_a;
  logic          data_a, busy_a, fd_a;
  logic [2:0]    st_a;

  // free-running chain
  logic          write_b = 1'b0, refresh_b = 1'b0;
  logic [NL-1:0] mask_b = '0;
  logic [BPL-1:0] colour_b = '0;
  logic          data_b, busy_b, fd_b;
  logic [2:0]    st_b;
  logic          b_done = 1'b0;

  // 32-bit chain
  logic          write_c, refresh_c;
  logic [1:0]    mask_c;
  logic [31:0]   colour_c;
  logic          data_c, busy_c, fd_c;
  logic [2:0]    st_c;

  ws2812_chain #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .T0H_CYC(T0H), .T1H_CYC(T1H),
                 .TBIT_CYC(TBIT), .TRESET_CYC(TRST), .AUTO_REFRESH(0)) dut_a (
    .clk(clk), .reset(rst_n), .write(write_a), .led_mask(mask_a), .colour(colour_a),
    .brightness(brightness), .refresh(refresh_a), .data(data_a), .busy(busy_a),
    .frame_done(fd_a), .state_dbg(st_a));

  ws2812_chain #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .T0H_CYC(T0H), .T1H_CYC(T1H),
                 .TBIT_CYC(TBIT), .TRESET_CYC(TRST), .AUTO_REFRESH(1)) dut_b (
    .clk(clk), .reset(rst_n), .write(write_b), .led_mask(mask_b), .colour(colour_b),
    .brightness(brightness), .refresh(refresh_b), .data(data_b), .busy(busy_b),
    .frame_done(fd_b), .state_dbg(st_b));

  ws2812_chain #(.NUM_LEDS(2), .BITS_PER_LED(32), .T0H_CYC(T0H), .T1H_CYC(T1H),
                 .TBIT_CYC(TBIT), .TRESET_CYC(TRST), .AUTO_REFRESH(0)) dut_c (
    .clk(clk), .reset(rst_n), .write(write_c), .led_mask(mask_c), .colour(colour_c),
    .brightness(brightness), .refresh(refresh_c), .data(data_c), .busy(busy_c),
    .frame_done(fd_c), .state_dbg(st_c));

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [BPL-1:0] m_reg [NL];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] scaled(input logic [31:0] w, input int nbytes);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < nbytes; k++) begin
`ifdef WS2812_CHAIN_BRIGHTNESS_EN
      r[k*8 +: 8] = 8'((int'(w[k*8 +: 8]) * (int'(brightness) + 1)) / 256);
`else
      r[k*8 +: 8] = w[k*8 +: 8];
`endif
    end
    return r;
  endfunction

  // driver tasks
  task automatic write_leds(input logic [NL-1:0] mask, input logic [BPL-1:0] col);
    @(negedge clk);
    write_a = 1'b1; mask_a = mask; colour_a = col;
    @(negedge clk);
    write_a = 1'b0; mask_a = '0;
    for (int i = 0; i < NL; i++) if (mask[i]) m_reg[i] = col;
  endtask

  task automatic push_led(input logic [BPL-1:0] w);
    exp_q.push_back(scaled(32'(w), BPL / 8));
  endtask

  task automatic start_frame();
    @(negedge clk);
    refresh_a = 1'b1;
    @(posedge clk);
    #1 refresh_a = 1'b0;
    check_eq("load_busy", 32'(busy_a), 32'd1);
    check_eq("load_state", 32'(st_a), 32'd1);
    check_eq("load_data_low", 32'(data_a), 32'd0);
    @(posedge clk);
    #1 check_eq("first_bit_high", 32'(data_a), 32'd1);
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh_a = 1'b1;
    @(negedge clk); refresh_a = 1'b0;
  endtask

  // line monitor for the on-demand chain
  logic        mon_en = 1'b0;
  logic        prev_d = 1'b0, prev_fd = 1'b0, in_frame = 1'b0, fd_busy = 1'b0;
  int          hi_len = 0, lo_len = 0, bit_idx = 0, last_hi = 0, rises = 0, frames = 0;
  logic [31:0] cur_exp = '0, word_a = '0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (fd_a) begin
        check_eq("fd_width", 32'(prev_fd), 32'd0);
        if (in_frame) check_eq("latch_gap", lo_len, TBIT - last_hi + TRST);
        in_frame = 1'b0;
        frames++;
        fd_busy = busy_a;
      end
      if (data_a && !prev_d) begin
        rises++;
        if (in_frame) check_eq("bit_period", hi_len + lo_len, TBIT);
        if (bit_idx == 0) begin
          check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          word_a = '0;
        end
        in_frame = 1'b1;
        hi_len = 1;
      end else if (data_a) begin
        hi_len++;
      end else if (prev_d) begin
        check_eq("bit_high", hi_len, cur_exp[BPL-1-bit_idx] ? T1H : T0H);
        word_a = {word_a[30:0], (hi_len > (T0H + T1H) / 2)};
        last_hi = hi_len;
        lo_len = 1;
        bit_idx++;
        if (bit_idx == BPL) begin
          check_eq("led_word", word_a, cur_exp);
          bit_idx = 0;
        end
      end else begin
        lo_len++;
      end
      prev_d = data_a;
      prev_fd = fd_a;
    end else begin
      prev_d = 1'b0; prev_fd = 1'b0; in_frame = 1'b0;
      bit_idx = 0; hi_len = 0; lo_len = 0;
    end
  end

  task automatic wait_frames(input int n);
    for (int k = 0; k < FRAME_CYC + 200 && frames < n; k++) begin
      @(negedge clk);
      #1;
    end
    check_eq("frames_seen", frames, n);
  endtask

  // free-running chain: first rise after reset and frame-to-frame spacing
  initial begin : auto_chk
    int n, t_prev, gaps;
    @(posedge rst_n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1; n++;
      if (data_b) break;
    end
    check_eq("auto_first_rise", n, TRST + 1);
    t_prev = -1;
    gaps = 0;
    while (gaps < 2 && n < 10000) begin
      @(posedge clk); #1; n++;
      if (fd_b) begin
        check_eq("auto_fd_busy", 32'(busy_b), 32'd1);
        if (t_prev >= 0) begin
          check_eq("auto_fd_gap", n - t_prev, FRAME_CYC);
          gaps++;
        end
        t_prev = n;
      end
    end
    check_eq("auto_gaps_seen", gaps, 2);
    b_done = 1'b1;
  end

  // main sequence
  initial begin
    logic [31:0] word_c, exp_c;
    int r0, hi, seen;
    rst_n = 1'b0; brightness = 8'h7F;
    write_a = 1'b0; refresh_a = 1'b0; mask_a = '0; colour_a = '0;
    write_c = 1'b0; refresh_c = 1'b0; mask_c = '0; colour_c = '0;
    for (int i = 0; i < NL; i++) m_reg[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(data_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_fd", 32'(fd_a), 32'd0);
    check_eq("rst_state", 32'(st_a), 32'd0);
    check_eq("rst_auto_data", 32'(data_b), 32'd0);
    check_eq("rst_auto_busy", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    repeat (200) @(negedge clk);
    #1;
    check_eq("idle_no_rise", rises, 0);
    check_eq("idle_busy", 32'(busy_a), 32'd0);

    // frame 1: alternate LEDs loaded, others still at reset value
    write_leds(4'b0101, 24'hAACCDD);
    for (int i = 0; i < NL; i++) push_led(m_reg[i]);
    start_frame();
    wait_frames(1);
    check_eq("f1_end_busy", 32'(fd_busy), 32'd0);

    // frame 2: mid-frame writes to an unloaded and an already-loaded LED
    write_leds(4'b0010, 24'h123456);
    push_led(24'hAACCDD); push_led(24'h123456); push_led(24'hAACCDD); push_led(24'hFFFFFF);
    start_frame();
    repeat (400) @(negedge clk);
    write_leds(4'b1001, 24'hFFFFFF);
    pulse_refresh();
    repeat (50) @(negedge clk);
    pulse_refresh();
    for (int i = 0; i < NL; i++) push_led(m_reg[i]);
    wait_frames(2);
    check_eq("f2_chains_busy", 32'(fd_busy), 32'd1);
    wait_frames(3);
    check_eq("f3_end_busy", 32'(fd_busy), 32'd0);
    r0 = rises;
    repeat (100) @(negedge clk);
    #1;
    check_eq("single_extra_frame", rises, r0);
    check_eq("sb_drained", exp_q.size(), 0);

    // 32-bit word on the RGBW chain, sampled between the 0 and 1 high times
    @(negedge clk);
    write_c = 1'b1; mask_c = 2'b01; colour_c = 32'hFF80_4000;
    @(negedge clk);
    write_c = 1'b0; mask_c = '0;
`ifdef WS2812_CHAIN_BRIGHTNESS_EN
    exp_c = 32'h7F40_2000;
`else
    exp_c = 32'hFF80_4000;
`endif
    @(negedge clk);
    refresh_c = 1'b1;
    @(posedge clk);
    #1 refresh_c = 1'b0;
    @(posedge clk);
    #1;
    word_c = '0;
    for (int k = 0; k < 32; k++) begin
      repeat ((k == 0) ? 5 : 15) @(posedge clk);
      #1 word_c = {word_c[30:0], data_c};
    end
    check_eq("rgbw_word", word_c, exp_c);
    seen = 0;
    for (int k = 0; k < 3000 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (fd_c) seen = 1;
    end
    check_eq("rgbw_frame_done", seen, 1);

    for (int k = 0; k < 20000 && !b_done; k++) @(negedge clk);
    check_eq("auto_checks_done", 32'(b_done), 32'd1);

    // asynchronous reset in the middle of a bit, with a request pending
    mon_en = 1'b0;
    pulse_refresh();
    repeat (30) @(negedge clk);
    pulse_refresh();
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (data_a) seen = 1;
    end
    check_eq("pre_reset_high", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_data", 32'(data_a), 32'd0);
    check_eq("async_rst_busy", 32'(busy_a), 32'd0);
    check_eq("async_rst_state", 32'(st_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (data_a || busy_a) hi++;
    end
    check_eq("pending_dropped", hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
